// File: rtl/sub_serial_if.sv
// Operand and result handshake bundle for the bit-serial subtractor.
// The slave modport is the subtractor side; the master modport is the producer/consumer side.
interface sub_serial_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] borrow;
  logic             bout;
  logic             busy;

  modport slave (
    input  in_valid, x, y, out_ready,
    output in_ready, out_valid, diff, borrow, bout, busy
  );

  modport master (
    output in_valid, x, y, out_ready,
    input  in_ready, out_valid, diff, borrow, bout, busy
  );
endinterface

// File: rtl/sub_serial.sv
// Bit-serial two's-complement subtractor: diff = x - y, one bit per clock, LSB first,
// with the full per-bit borrow chain exposed alongside the result.
module sub_serial #(
  parameter int unsigned WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  sub_serial_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] x_q, y_q;
  logic [WIDTH-1:0] diff_q, borrow_q;
  logic [CntW-1:0]  cnt_q;
  logic             b_q;
  logic             out_valid_q, in_ready_q, busy_q;

  // Full-subtract cell on the current LSB of the operand shift registers.
  logic xi, yi, d, bo;
  always_comb begin
    xi = x_q[0];
    yi = y_q[0];
    d  = xi ^ yi ^ b_q;
    bo = (~xi & yi) | (~(xi ^ yi) & b_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      diff_q      <= '0;
      borrow_q    <= '0;
      cnt_q       <= '0;
      b_q         <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid && in_ready_q) begin
            x_q        <= bus.x;
            y_q        <= bus.y;
            diff_q     <= '0;
            borrow_q   <= '0;
            cnt_q      <= '0;
            b_q        <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= StShift;
          end
        end
        StShift: begin
          x_q             <= x_q >> 1;
          y_q             <= y_q >> 1;
          diff_q[cnt_q]   <= d;
          borrow_q[cnt_q] <= bo;
          b_q             <= bo;
          // Counter parks on the last index rather than wrapping.
          if (cnt_q == CntLast) begin
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;
  assign bus.bout      = borrow_q[WIDTH-1];
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_sub_serial.sv
// Directed and randomized checks of sub_serial against an arithmetic reference model.
module tb_sub_serial;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  sub_serial_if #(.WIDTH(W)) bus ();

  sub_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  // Borrow out of bit i is set exactly when the low i+1 bits of x are below those of y.
  function automatic logic [W-1:0] model_borrow(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      int unsigned m;
      m    = (32'd1 << (i + 1)) - 1;
      r[i] = ((32'(a) & m) < (32'(b) & m));
    end
    return r;
  endfunction

  // One full transaction; optional early out_ready and an ignored in_valid pulse mid-shift.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] ed, input logic [W-1:0] eb, input logic ebo,
                       input bit rdy_early, input bit intrude, input bit verbose);
    int cyc;
    @(negedge clk);
    if (verbose) chk({tag, ".in_ready_idle"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.x         = a;
    bus.y         = b;
    bus.out_ready = rdy_early;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.x        = ~a;
    bus.y        = a ^ b;
    cyc = 0;
    while (!bus.out_valid && cyc < 40) begin
      if (intrude && cyc == 2) begin
        chk({tag, ".in_ready_busy"}, 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b1;
        bus.x        = 8'hFF;
        bus.y        = 8'h01;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk({tag, ".latency"}, 32'(cyc), 32'(W));
    chk({tag, ".diff"}, 32'(bus.diff), 32'(ed));
    chk({tag, ".borrow"}, 32'(bus.borrow), 32'(eb));
    chk({tag, ".bout"}, 32'(bus.bout), 32'(ebo));
    if (verbose) begin
      chk({tag, ".in_ready_done"}, 32'(bus.in_ready), 32'd0);
      chk({tag, ".busy_done"}, 32'(bus.busy), 32'd1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, ".out_valid_drop"}, 32'(bus.out_valid), 32'd0);
    if (verbose) begin
      chk({tag, ".in_ready_back"}, 32'(bus.in_ready), 32'd1);
      chk({tag, ".busy_clear"}, 32'(bus.busy), 32'd0);
      chk({tag, ".diff_held"}, 32'(bus.diff), 32'(ed));
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    bit           seen_valid;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.x         = '0;
    bus.y         = '0;

    // Asynchronous reset mid-cycle, checked before any clock edge.
    #3 rst_n = 1'b0;
    #1;
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.diff", 32'(bus.diff), 32'd0);
    chk("rst.borrow", 32'(bus.borrow), 32'd0);
    chk("rst.bout", 32'(bus.bout), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("zero", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    do_op("a2m5f", 8'hA2, 8'h5F, 8'h43, 8'h5F, 1'b0, 1'b0, 1'b0, 1'b1);
    do_op("5fma2", 8'h5F, 8'hA2, 8'hBD, 8'hA0, 1'b1, 1'b0, 1'b0, 1'b1);

    // Backpressure: out_ready held low keeps DONE with stable outputs.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.x        = 8'h00;
    bus.y        = 8'h01;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 40 && !bus.out_valid; i++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp.out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp.diff", 32'(bus.diff), 32'hFF);
      chk("bp.borrow", 32'(bus.borrow), 32'hFF);
      chk("bp.bout", 32'(bus.bout), 32'd1);
      chk("bp.in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp.release", 32'(bus.out_valid), 32'd0);

    // in_valid during SHIFT must be ignored.
    do_op("intrude", 8'h3C, 8'hA5, 8'h97, model_borrow(8'h3C, 8'hA5), 1'b1, 1'b0, 1'b1, 1'b1);

    // Randomized scoreboard with out_ready asserted early to show it has no effect outside DONE.
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      do_op("rand", ra, rb, W'(32'(ra) - 32'(rb)), model_borrow(ra, rb), (ra < rb),
            1'b1, 1'b0, 1'b0);
    end

    // Reset at cnt=3 aborts the operation and never flags a result.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.x        = 8'h12;
    bus.y        = 8'h34;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort.out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort.in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort.busy", 32'(bus.busy), 32'd0);
    chk("abort.diff", 32'(bus.diff), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen_valid = 1'b1;
    end
    chk("abort.no_valid", 32'(seen_valid), 32'd0);
    do_op("fresh", 8'h12, 8'h34, 8'hDE, model_borrow(8'h12, 8'h34), 1'b1, 1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
